photonic_receiver: RTL and testbench
====================================

# photonic_receiver

Receive-side endpoint of the photonic interconnect. It consumes the `{dest_id, data, src_id}` word driven by a transmitter onto the link and keeps only words addressed to this node's `my_id`. Accepted `(data, src_id)` pairs are buffered in a small first-word-fall-through FIFO for the local core. Overflow losses are counted. One instance sits at each node, directly downstream of the link fed by the transmitters.

## Interface
- `ID_WIDTH`, default 2: width of `dest_id`, `src_id` and `my_id`.
- `DATA_WIDTH`, default 2: payload width.
- `DEPTH`, default 4: FIFO entries. Must be a power of two and ≥ 2.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `my_id`  in  ID_WIDTH  node address. Quasi-static.
- `rx_in`  in  2*ID_WIDTH+DATA_WIDTH  link word. Fields from MSB to LSB are `dest_id`, then `data`, then `src_id`.
- `rx_valid`  in  1  `rx_in` holds a packet this cycle (the transmitter's `enable`).
- `rd_en`  in  1  pop the head entry.
- `rd_data`  out  DATA_WIDTH  head payload.
- `rd_src`  out  ID_WIDTH  head source id.
- `empty`  out  1  FIFO empty.
- `full`  out  1  FIFO full.
- `count`  out  $clog2(DEPTH)+1  occupancy.
- `rx_hit`  out  1  one-cycle pulse: a packet was written into the FIFO this edge.
- `drop_cnt`  out  8  matched packets lost to overflow. Saturates at 255.

## Operation
- **Stage 1, capture.** Every edge registers `rx_in` and `rx_valid` into `cap_word` and `cap_valid`. There is no combinational path from `rx_in` to any output.
- **Stage 2, filter.**
  - `match = cap_valid && (cap_word.dest_id == my_id)`.
  - A mismatched or invalid word is discarded silently. It does not increment `drop_cnt`.
- **Write.**
  - If `match` and the FIFO is not full, write `{data, src_id}` at `wr_ptr`, increment `wr_ptr` and assert `rx_hit` for one cycle.
  - If `match`, the FIFO is full and `rd_en` is asserted the same cycle: the write succeeds. The slot freed by the pop is reused, `count` is unchanged and there is no drop.
  - If `match`, the FIFO is full and `rd_en` is low: the packet is dropped and `drop_cnt` increments, saturating at 255.
- **Read.**
  - `rd_data`/`rd_src` always show the entry at `rd_ptr` (first-word fall-through).
  - `rd_en` with `empty=1` is ignored: no pointer movement and `count` does not underflow.
  - `rd_en` and a write while empty: only the write takes effect.
- **Pointers.**
  - `wr_ptr` and `rd_ptr` are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
  - `count` changes by +1 for a write only, −1 for a read only, and 0 for both or neither.
  - `empty = (count==0)`, `full = (count==DEPTH)`.
- **Reset** (`rst_n`=0 at an edge) applies regardless of traffic:
  - `cap_valid`, both pointers, `count`, `rx_hit` and `drop_cnt` go to 0.
  - `empty`=1, `full`=0.
  - `rd_data`/`rd_src` read 0 (storage cleared).
  - A packet held in the capture stage at that edge is lost.
  - Words presented while `rst_n`=0 are never captured.

## Timing
- Packet latency is 2 edges. A packet with `rx_valid` high before edge N is captured at N, written at N+1, and visible on `rd_data`/`rd_src` with `empty`=0 after N+1.
- The block accepts one packet per cycle. Back-to-back `rx_valid` is sustained with no bubbles.
- A pop at edge M updates the head, `count` and `empty` after M.
- `rx_hit` is registered: it is high in the cycle following the write edge.
- All outputs are registered, except `rd_data`/`rd_src`, which are a mux of registered storage by registered `rd_ptr`.

## Test plan
All scenarios use `my_id`=01, the default parameters, and a 6-bit `rx_in`.
1. **Reset.** Hold `rst_n`=0 for 2 cycles with `rx_valid`=1 and `rx_in`=011011 → after release: `empty`=1, `count`=0, `drop_cnt`=0, `rx_hit`=0, `rd_data`=00.
2. **Match.** `rx_in`=011011 with `rx_valid`=1 for one cycle → 2 edges later `empty`=0, `count`=1, `rd_data`=10, `rd_src`=11, `rx_hit` pulsed once. Then `rd_en`=1 for one cycle → `empty`=1.
3. **Filter.**
   - `rx_in`=101011 with `rx_valid`=1 → FIFO stays empty and `drop_cnt` stays 0.
   - `rx_in`=011011 with `rx_valid`=0 → FIFO stays empty.
4. **Overflow.** Five back-to-back matched packets with payloads 00, 01, 10, 11, 00 and no reads → `full`=1, `count`=4, `drop_cnt`=1. Four pops then return 00, 01, 10, 11 in order, after which `empty`=1.
5. **Full plus simultaneous read/write.**
   - Fill to 4, then one matched packet arrives in the same cycle its write coincides with `rd_en`=1 → `count` stays 4 and `drop_cnt` is unchanged. The new payload is returned fourth on drain.
   - Continue cycling to check pointer wrap.
6. **Reset mid-stream.** `rst_n`=0 while a packet is in the capture stage and the FIFO holds 2 entries → after the reset edge `count`=0 and `empty`=1. The in-flight packet is never written.

Source files
------------

// File: rtl/photonic_receiver.sv
// Receive endpoint of the photonic link: captures the link word, keeps only packets
// addressed to my_id, and queues (data, src_id) in a first-word-fall-through FIFO.
module photonic_receiver #(
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH      = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [ID_WIDTH-1:0]             my_id,
  input  logic [2*ID_WIDTH+DATA_WIDTH-1:0] rx_in,
  input  logic                            rx_valid,
  input  logic                            rd_en,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic [ID_WIDTH-1:0]             rd_src,
  output logic                            empty,
  output logic                            full,
  output logic [$clog2(DEPTH):0]          count,
  output logic                            rx_hit,
  output logic [7:0]                      drop_cnt
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_WIDTH + ID_WIDTH;
  localparam int WORD_W  = 2*ID_WIDTH + DATA_WIDTH;

  logic [WORD_W-1:0]  cap_word_reg;
  logic               cap_valid_reg;
  logic [ENTRY_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W-1:0]   count_next;
  logic               empty_reg;
  logic               full_reg;
  logic               rx_hit_reg;
  logic [7:0]         drop_cnt_reg;
  logic               match;
  logic               do_wr;
  logic               do_rd;
  logic               do_drop;
  logic [ENTRY_W-1:0] head;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_word_reg  <= '0;
      cap_valid_reg <= 1'b0;
    end else begin
      cap_word_reg  <= rx_in;
      cap_valid_reg <= rx_valid;
    end
  end

  // A full FIFO still accepts a write when the same edge pops, reusing the freed slot.
  always_comb begin
    match      = cap_valid_reg && (cap_word_reg[WORD_W-1 -: ID_WIDTH] == my_id);
    do_rd      = rd_en && !empty_reg;
    do_wr      = match && (!full_reg || rd_en);
    do_drop    = match && full_reg && !rd_en;
    count_next = count_reg + CNT_W'(do_wr) - CNT_W'(do_rd);
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          mem_reg[gi] <= '0;
        end else if (do_wr && (wr_ptr_reg == PTR_W'(gi))) begin
          mem_reg[gi] <= cap_word_reg[ENTRY_W-1:0];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      empty_reg    <= 1'b1;
      full_reg     <= 1'b0;
      rx_hit_reg   <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg  <= count_next;
      empty_reg  <= (count_next == '0);
      full_reg   <= (count_next == CNT_W'(DEPTH));
      rx_hit_reg <= do_wr;
      if (do_drop && (drop_cnt_reg != 8'hFF)) drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign head     = mem_reg[rd_ptr_reg];
  assign rd_data  = head[ENTRY_W-1:ID_WIDTH];
  assign rd_src   = head[ID_WIDTH-1:0];
  assign empty    = empty_reg;
  assign full     = full_reg;
  assign count    = count_reg;
  assign rx_hit   = rx_hit_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_photonic_receiver.sv
// Directed bench for photonic_receiver: stimulus pushes expected pops and status
// checks into queues; a negedge monitor pops and compares them.
module tb_photonic_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] my_id;
  logic [5:0] rx_in;
  logic       rx_valid;
  logic       rd_en;
  logic [1:0] rd_data;
  logic [1:0] rd_src;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       rx_hit;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string name;
    int    sel;
    int    exp;
  } chk_t;

  chk_t       chk_q[$];
  logic [3:0] sb_q[$];

  photonic_receiver dut (
    .clk(clk), .rst_n(rst_n), .my_id(my_id), .rx_in(rx_in), .rx_valid(rx_valid),
    .rd_en(rd_en), .rd_data(rd_data), .rd_src(rd_src), .empty(empty), .full(full),
    .count(count), .rx_hit(rx_hit), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Status check evaluated by the monitor at the next falling edge.
  task automatic expect_sig(input string name, input int sel, input int exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic send(input logic [1:0] dest, input logic [1:0] data, input logic [1:0] src,
                      input bit stored);
    rx_in    = {dest, data, src};
    rx_valid = 1'b1;
    if (stored) sb_q.push_back({data, src});
    step();
  endtask

  // Monitor: status checks plus head comparison whenever a pop is presented.
  initial begin
    chk_t       c;
    int         act;
    logic [3:0] e;
    forever begin
      @(negedge clk);
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        case (c.sel)
          0: act = int'(count);
          1: act = int'(empty);
          2: act = int'(full);
          3: act = int'(drop_cnt);
          4: act = int'(rx_hit);
          5: act = int'(rd_data);
          6: act = int'(rd_src);
          default: act = sb_q.size();
        endcase
        n_checks++;
        if (act != c.exp) begin
          n_fail++;
          $display("FAIL %s: got %0d expected %0d", c.name, act, c.exp);
        end
      end
      if (rst_n && rd_en && !empty) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL pop_unexpected: got %b_%b expected no entry", rd_data, rd_src);
        end else begin
          e = sb_q.pop_front();
          $display("pop data=%b src=%b (expected %b_%b)", rd_data, rd_src, e[3:2], e[1:0]);
          if ({rd_data, rd_src} != e) begin
            n_fail++;
            $display("FAIL pop_head: got %b expected %b", {rd_data, rd_src}, e);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    my_id    = 2'b01;
    rd_en    = 1'b0;
    rst_n    = 1'b0;
    rx_valid = 1'b1;
    rx_in    = 6'b011011;

    // 1. reset with a matching word on the link
    step();
    step();
    rst_n    = 1'b1;
    rx_valid = 1'b0;
    expect_sig("rst_empty", 1, 1);
    expect_sig("rst_count", 0, 0);
    expect_sig("rst_drop", 3, 0);
    expect_sig("rst_hit", 4, 0);
    expect_sig("rst_rd_data", 5, 0);
    expect_sig("rst_full", 2, 0);
    step();
    expect_sig("rst_no_capture_empty", 1, 1);

    // 2. single match, two-edge latency, one-cycle rx_hit
    send(2'b01, 2'b10, 2'b11, 1'b1);
    rx_valid = 1'b0;
    expect_sig("match_lat1_empty", 1, 1);
    expect_sig("match_lat1_hit", 4, 0);
    step();
    expect_sig("match_empty", 1, 0);
    expect_sig("match_count", 0, 1);
    expect_sig("match_rd_data", 5, 2);
    expect_sig("match_rd_src", 6, 3);
    expect_sig("match_hit", 4, 1);
    step();
    expect_sig("match_hit_clear", 4, 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    expect_sig("match_pop_empty", 1, 1);
    expect_sig("match_pop_count", 0, 0);

    // 3. filter: wrong destination, then rx_valid low
    send(2'b10, 2'b10, 2'b11, 1'b0);
    rx_valid = 1'b0;
    step();
    step();
    expect_sig("filter_dest_empty", 1, 1);
    expect_sig("filter_dest_drop", 3, 0);
    expect_sig("filter_dest_hit", 4, 0);
    rx_in = 6'b011011;
    step();
    step();
    step();
    expect_sig("filter_invalid_empty", 1, 1);
    expect_sig("filter_invalid_count", 0, 0);

    // 4. overflow: fifth back-to-back packet is dropped
    send(2'b01, 2'b00, 2'b01, 1'b1);
    send(2'b01, 2'b01, 2'b10, 1'b1);
    send(2'b01, 2'b10, 2'b11, 1'b1);
    send(2'b01, 2'b11, 2'b00, 1'b1);
    send(2'b01, 2'b00, 2'b01, 1'b0);
    rx_valid = 1'b0;
    step();
    expect_sig("ovf_full", 2, 1);
    expect_sig("ovf_count", 0, 4);
    expect_sig("ovf_drop", 3, 1);
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rd_en = 1'b0;
    expect_sig("ovf_drain_empty", 1, 1);
    expect_sig("ovf_drain_count", 0, 0);

    // 5. full plus simultaneous pop and write, then streaming across pointer wrap
    send(2'b01, 2'b11, 2'b01, 1'b1);
    send(2'b01, 2'b10, 2'b10, 1'b1);
    send(2'b01, 2'b01, 2'b11, 1'b1);
    send(2'b01, 2'b00, 2'b00, 1'b1);
    send(2'b01, 2'b10, 2'b01, 1'b1);
    rx_valid = 1'b0;
    rd_en    = 1'b1;
    step();
    rd_en = 1'b0;
    expect_sig("rw_full_count", 0, 4);
    expect_sig("rw_full_full", 2, 1);
    expect_sig("rw_full_drop", 3, 1);
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rd_en = 1'b0;
    expect_sig("rw_drain_empty", 1, 1);
    rd_en = 1'b1;
    for (int i = 0; i < 6; i++) send(2'b01, 2'(i), 2'(3 - (i % 4)), 1'b1);
    rx_valid = 1'b0;
    step();
    step();
    rd_en = 1'b0;
    expect_sig("wrap_empty", 1, 1);
    expect_sig("wrap_count", 0, 0);
    expect_sig("wrap_drop", 3, 1);
    expect_sig("wrap_sb_drained", 7, 0);

    // 6. reset while two entries are queued and one packet is in capture
    send(2'b01, 2'b01, 2'b01, 1'b0);
    send(2'b01, 2'b10, 2'b10, 1'b0);
    send(2'b01, 2'b11, 2'b11, 1'b0);
    expect_sig("mid_pre_count", 0, 2);
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
    expect_sig("mid_rst_count", 0, 0);
    expect_sig("mid_rst_empty", 1, 1);
    expect_sig("mid_rst_drop", 3, 0);
    expect_sig("mid_rst_rd_data", 5, 0);
    step();
    step();
    expect_sig("mid_inflight_lost_count", 0, 0);
    expect_sig("mid_inflight_lost_hit", 4, 0);

    step();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
